// File: rtl/muldiv_unit_pkg.sv
// Shared operation codes, FSM state encodings and op-decoding helpers for muldiv_unit.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_MULU = 2'd1,
    OP_DIV  = 2'd2,
    OP_DIVU = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_unit_cneg.sv
// Conditional two's-complement negation: y = neg ? -x : x, at W bits.
module muldiv_cneg #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + W'(1)) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider sharing one accumulator,
// driven by an alternating-bit request/acknowledge handshake.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             sys_clock_i,
  input  logic             sys_reset_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [1:0]       op_i,
  input  logic             abp_req_i,
  output logic             abp_ack_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_hi_o,
  output logic [WIDTH-1:0] result_lo_o,
  output logic             dbz_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int W2 = 2 * WIDTH;

  state_e         state;
  op_e            op;
  logic           req_last;
  logic           neg_q;
  logic           neg_r;
  logic           dbz_pend;
  logic [CW-1:0]  count;
  logic [W2-1:0]  ma;
  logic [W2-1:0]  acc;
  logic [WIDTH-1:0] mb;
  logic [WIDTH-1:0] raw_a;

  // Operand decode and magnitudes for the request being presented.
  op_e              op_in;
  logic             sgn_in;
  logic             neg_a_in;
  logic             neg_b_in;
  logic             div_in;
  logic             dbz_in;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign op_in    = op_e'(op_i);
  assign sgn_in   = op_is_signed(op_in);
  assign neg_a_in = sgn_in & a_i[WIDTH-1];
  assign neg_b_in = sgn_in & b_i[WIDTH-1];
  assign div_in   = op_is_div(op_in);
  assign dbz_in   = div_in && (b_i == '0);

  muldiv_cneg #(.W(WIDTH)) u_neg_a (.x(a_i), .neg(neg_a_in), .y(a_mag));
  muldiv_cneg #(.W(WIDTH)) u_neg_b (.x(b_i), .neg(neg_b_in), .y(b_mag));

  // Per-cycle datapath: acc holds the product for multiplies, and
  // {remainder, dividend/quotient} for divides; mb holds multiplier or divisor.
  logic [W2-1:0]    mul_sum;
  logic [WIDTH-1:0] mb_shift;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic             last_step;

  assign mul_sum   = mb[0] ? (acc + ma) : acc;
  assign mb_shift  = mb >> 1;
  assign trial     = {acc[W2-1:WIDTH], acc[WIDTH-1]};
  assign q_bit     = (trial >= {1'b0, mb});
  assign rem_next  = q_bit ? WIDTH'(trial - {1'b0, mb}) : trial[WIDTH-1:0];
  assign last_step = (count == CW'(1));

  // Sign fix-up applied only when results are published.
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;

  muldiv_cneg #(.W(W2))    u_fix_p (.x(acc),              .neg(neg_q), .y(prod_fix));
  muldiv_cneg #(.W(WIDTH)) u_fix_q (.x(acc[WIDTH-1:0]),   .neg(neg_q), .y(quot_fix));
  muldiv_cneg #(.W(WIDTH)) u_fix_r (.x(acc[W2-1:WIDTH]),  .neg(neg_r), .y(rem_fix));

  // NOTE: every register here is state, so all updates use non-blocking
  // assignments; the reset branch clears the whole datapath, not just the FSM.
  always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
    if (sys_reset_i) begin
      state       <= ST_IDLE;
      op          <= OP_MUL;
      req_last    <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dbz_pend    <= 1'b0;
      count       <= '0;
      ma          <= '0;
      acc         <= '0;
      mb          <= '0;
      raw_a       <= '0;
      abp_ack_o   <= 1'b0;
      busy_o      <= 1'b0;
      result_hi_o <= '0;
      result_lo_o <= '0;
      dbz_o       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (abp_req_i != req_last) begin
            op       <= op_in;
            req_last <= abp_req_i;
            count    <= CW'(WIDTH);
            neg_q    <= sgn_in & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_r    <= neg_a_in;
            raw_a    <= a_i;
            mb       <= b_mag;
            dbz_pend <= dbz_in;
            busy_o   <= 1'b1;
            if (div_in) begin
              ma  <= '0;
              acc <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              ma  <= {{WIDTH{1'b0}}, a_mag};
              acc <= '0;
            end
            state <= dbz_in ? ST_FIX : ST_CALC;
          end
        end

        ST_CALC: begin
          count <= count - CW'(1);
          if (op_is_div(op)) begin
            acc <= {rem_next, acc[WIDTH-2:0], q_bit};
            if (last_step) state <= ST_FIX;
          end else begin
            acc <= mul_sum;
            ma  <= ma << 1;
            mb  <= mb_shift;
            // Early exit once no multiplier bits remain to be added in.
            if (last_step || (EARLY_OUT && (mb_shift == '0))) state <= ST_FIX;
          end
        end

        ST_FIX: begin
          abp_ack_o <= req_last;
          busy_o    <= 1'b0;
          state     <= ST_IDLE;
          if (dbz_pend) begin
            result_lo_o <= '1;
            result_hi_o <= raw_a;
            dbz_o       <= 1'b1;
          end else if (op_is_div(op)) begin
            result_lo_o <= quot_fix;
            result_hi_o <= rem_fix;
            dbz_o       <= 1'b0;
          end else begin
            result_lo_o <= prod_fix[WIDTH-1:0];
            result_hi_o <= prod_fix[W2-1:WIDTH];
            dbz_o       <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative integer multiplier/divider for the M1 CPU execute stage. It replaces the separate fixed-32-bit multiplier and divider with one shared datapath. The unit is driven over the Alternating Bit Protocol (ABP) request/acknowledge pair. It adds configurable width, unsigned multiply early termination, divide-by-zero reporting and correct signed remainder sign.

## Interface
- WIDTH, 32: operand width in bits, even, ≥ 4.
- EARLY_OUT, 1: if 1, a multiply leaves CALC once the remaining multiplier bits are all zero.
- sys_clock_i  in  1  system clock; all state updates on the rising edge.
- sys_reset_i  in  1  reset, asynchronous, active-high.
- a_i  in  WIDTH  operand A (multiplicand / dividend).
- b_i  in  WIDTH  operand B (multiplier / divisor).
- op_i  in  2  operation: MUL=0, MULU=1, DIV=2, DIVU=3.
- abp_req_i  in  1  ABP request; each level change starts one operation.
- abp_ack_o  out  1  ABP acknowledge; set equal to the accepted request level when the result is valid.
- busy_o  out  1  high while an operation is in progress (CALC or FIX).
- result_hi_o  out  WIDTH  product high half (MUL*) or remainder (DIV*).
- result_lo_o  out  WIDTH  product low half (MUL*) or quotient (DIV*).
- dbz_o  out  1  divide by zero flag for the last result; cleared by any non-zero-divisor result.

## Operation
- Reset value of every output is 0. State resets to IDLE, with the internal req_last register at 0 and count at 0.
- IDLE: when abp_req_i != req_last, the unit does the following on that edge:
  - latches op_i and the magnitudes |a|, |b|; operands are treated as signed only for MUL and DIV;
  - stores neg_q = signed & (a[W-1]^b[W-1]) and neg_r = signed & a[W-1];
  - sets req_last = abp_req_i and count = WIDTH;
  - goes to CALC. If the op is DIV* and b_i == 0, it goes to FIX directly.
- CALC, multiply: shift-add, one multiplier bit per cycle.
  - Each cycle: if mb[0], prod += ma; then ma <<= 1, mb >>= 1, count--.
  - Exit to FIX when count reaches 0. With EARLY_OUT=1, also exit when mb is 0 after the shift.
- CALC, divide: restoring division, one quotient bit per cycle.
  - Each cycle the partial remainder is computed as rem = {rem, next dividend bit}.
  - If rem ≥ divisor, subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - count--; exit to FIX when count reaches 0.
- FIX is one cycle. It publishes the results:
  - MUL*: {result_hi_o, result_lo_o} = neg_q ? −prod : prod, computed at 2·WIDTH bits.
  - DIV*: result_lo_o = neg_q ? −q : q, and result_hi_o = neg_r ? −r : r.
  - Divide by zero: result_lo_o = all ones, result_hi_o = latched raw a_i, dbz_o = 1.
  - Signed overflow, −2^(W−1) / −1, gives quotient −2^(W−1) and remainder 0 with no flag. This falls out of the datapath naturally.
  - On the same edge FIX sets abp_ack_o = req_last and returns to IDLE.
- Result outputs are stable except on the FIX edge. There are no intermediate updates.
- Request toggles seen during CALC/FIX are a protocol violation and are not acted on. After returning to IDLE, if abp_req_i != req_last, a new operation starts using the then-current operands.
- Reset asserted mid-operation aborts immediately. All outputs return to 0, and no ack is produced for the aborted request.

## Timing
- Request toggle seen at edge N:
  - normal case: ack and results change at edge N+WIDTH+1;
  - divide by zero: ack and results change at edge N+1.
- EARLY_OUT multiply: latency is N + (index of the highest set bit of |b|) + 2. For |b| = 0 it is N+2: one CALC cycle, then FIX.
- busy_o is high from edge N up to, but not including, the edge after FIX.
- Back-to-back: the earliest next acceptance is the edge after FIX.

## Structure
- Shared constants go in m1_defs.h: MULDIV_OP_MUL/MULU/DIV/DIVU codes and the state encodings IDLE/CALC/FIX.
- One combinational sub-module, muldiv_cneg(x, neg, y), parametrised by width. It performs conditional two's-complement negation and is used for the operand magnitudes and for the result fix-up.
- Implementation is a single always block with an asynchronous reset branch plus muldiv_cneg instances, sized at 150–250 lines.

## Test plan
- WIDTH=32, MULU 17×3, toggle req → after 33 edges ack=req, hi=0, lo=51, dbz=0.
- MUL −7×3 with EARLY_OUT=1 → lo=0xFFFF_FFEB, hi=0xFFFF_FFFF, ack at edge N+3.
- DIV −7/2 → quotient 0xFFFF_FFFD (−3), remainder 0xFFFF_FFFF (−1); DIVU 17/5 → q=3, r=2.
- DIVU 5/0 → ack at N+1, lo=0xFFFF_FFFF, hi=5, dbz=1; the following DIVU 4/2 clears dbz.
- DIV 0x8000_0000/−1 → q=0x8000_0000, r=0; MULU 0xFFFF_FFFF² → hi=0xFFFF_FFFE, lo=1.
- Reset asserted at cycle 10 of a DIV → outputs 0 asynchronously, no ack. After release, toggle req → normal result. Also repeat a random signed/unsigned sweep at WIDTH=8 against a reference model.
